// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply (radix-2 Booth) and divide
// (restoring, on magnitudes). One step per clock, WIDTH steps per operation.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MultStart,
  input  logic             DivStart,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  // Accumulator fields: {upper word, lower word, Booth guard bit}.
  // During a divide the upper word is the partial remainder and the lower
  // word shifts out dividend bits while shifting in quotient bits.
  logic [WIDTH-1:0] hi_f_c;
  logic [WIDTH-1:0] lo_f_c;
  logic             qm1_c;
  logic             last_c;
  logic             b_zero_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;

  assign hi_f_c   = acc_q[AW-1:WIDTH+1];
  assign lo_f_c   = acc_q[WIDTH:1];
  assign qm1_c    = acc_q[0];
  assign last_c   = (cnt_q == CW'(1));
  assign b_zero_c = (B == '0);
  assign a_mag_c  = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
  assign b_mag_c  = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;

  // Booth step: add/subtract in WIDTH+1 bits so the arithmetic shift takes
  // the true sign even for the most-negative multiplicand.
  logic [WIDTH:0]   hi_ext_c;
  logic [WIDTH:0]   m_ext_c;
  logic [WIDTH:0]   booth_sum_c;
  logic [AW-1:0]    booth_next_c;

  always_comb begin
    hi_ext_c = {hi_f_c[WIDTH-1], hi_f_c};
    m_ext_c  = {mcand_q[WIDTH-1], mcand_q};
    case ({lo_f_c[0], qm1_c})
      2'b01:   booth_sum_c = hi_ext_c + m_ext_c;
      2'b10:   booth_sum_c = hi_ext_c - m_ext_c;
      default: booth_sum_c = hi_ext_c;
    endcase
    // {sum, lower} is exactly the accumulator shifted right by one.
    booth_next_c = {booth_sum_c, lo_f_c};
  end

  // Restoring divide step on magnitudes, plus final sign correction.
  logic [WIDTH:0]   div_shift_c;
  logic [WIDTH:0]   div_diff_c;
  logic [WIDTH-1:0] div_rem_c;
  logic [WIDTH-1:0] div_quo_c;
  logic [WIDTH-1:0] quo_fix_c;
  logic [WIDTH-1:0] rem_fix_c;
  logic [AW-1:0]    div_next_c;

  always_comb begin
    div_shift_c = {hi_f_c, lo_f_c[WIDTH-1]};
    div_diff_c  = div_shift_c - {1'b0, mcand_q};
    div_rem_c   = div_diff_c[WIDTH] ? div_shift_c[WIDTH-1:0] : div_diff_c[WIDTH-1:0];
    div_quo_c   = {lo_f_c[WIDTH-2:0], ~div_diff_c[WIDTH]};
    div_next_c  = {div_rem_c, div_quo_c, 1'b0};
    quo_fix_c   = neg_quo_q ? (~div_quo_c + WIDTH'(1)) : div_quo_c;
    rem_fix_c   = neg_rem_q ? (~div_rem_c + WIDTH'(1)) : div_rem_c;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; MultStart has priority, starts outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (MultStart) begin
          state_d = S_MULT;
        end else if (DivStart) begin
          state_d = b_zero_c ? S_DONE : S_DIV;
        end
      end
      S_MULT:  if (last_c) state_d = S_DONE;
      S_DIV:   if (last_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the next state so they are registered.
  always_comb begin
    busy_d = (state_d == S_MULT) || (state_d == S_DIV);
    done_d = (state_d == S_DONE);
  end

  // Datapath next values: operand capture, iteration, result write.
  always_comb begin
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (MultStart) begin
          acc_d      = {WIDTH'(0), B, 1'b0};
          mcand_d    = A;
          cnt_d      = CW'(WIDTH);
          div_zero_d = 1'b0;
        end else if (DivStart) begin
          acc_d      = {WIDTH'(0), a_mag_c, 1'b0};
          mcand_d    = b_mag_c;
          cnt_d      = CW'(WIDTH);
          neg_quo_d  = A[WIDTH-1] ^ B[WIDTH-1];
          neg_rem_d  = A[WIDTH-1];
          div_zero_d = b_zero_c;
        end
      end
      S_MULT: begin
        acc_d = booth_next_c;
        cnt_d = cnt_q - CW'(1);
        if (last_c) begin
          hi_d = booth_next_c[AW-1:WIDTH+1];
          lo_d = booth_next_c[WIDTH:1];
        end
      end
      S_DIV: begin
        acc_d = div_next_c;
        cnt_d = cnt_q - CW'(1);
        if (last_c) begin
          hi_d = rem_fix_c;
          lo_d = quo_fix_c;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      mcand_q    <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: vector table plus directed corner sequences.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic        MultStart;
  logic        DivStart;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  int total;
  int bad;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .MultStart(MultStart),
    .DivStart (DivStart),
    .Hi       (Hi),
    .Lo       (Lo),
    .Busy     (Busy),
    .Done     (Done),
    .DivZero  (DivZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        is_mult;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Issue one start pulse and follow the operation to completion.
  task automatic run_op(input logic ms, input logic ds, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input logic [31:0] ph, input logic [31:0] pl,
                        output int busy_n, output int done_n,
                        output logic [31:0] hi_d, output logic [31:0] lo_d,
                        output logic dz_d, output logic held);
    int guard;
    @(negedge clock);
    A = a; B = b; MultStart = ms; DivStart = ds;
    @(negedge clock);
    MultStart = 1'b0; DivStart = 1'b0;
    A = $urandom; B = $urandom;
    busy_n = 0; done_n = 0; guard = 0; held = 1'b1;
    while (!Done && guard < 100) begin
      if (Busy) busy_n++;
      if (Hi !== ph || Lo !== pl) held = 1'b0;
      DivStart = (inj != 0 && busy_n == inj);
      @(negedge clock);
      guard++;
    end
    DivStart = 1'b0;
    hi_d = Hi; lo_d = Lo; dz_d = DivZero;
    while (Done && guard < 100) begin
      done_n++;
      @(negedge clock);
      guard++;
    end
  endtask

  initial begin
    int          bn, dn;
    logic [31:0] rh, rl;
    logic        rdz, held, quiet;
    logic [31:0] ph, pl;

    total = 0; bad = 0;
    reset = 1'b0; A = '0; B = '0; MultStart = 1'b0; DivStart = 1'b0;

    vecs[0]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[2]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[4]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[5]  = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[6]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7]  = '{1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E};
    vecs[8]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[9]  = '{1'b0, 32'h0000_0005, 32'h0000_0007, 32'h0000_0005, 32'h0000_0000};
    vecs[10] = '{1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};

    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst_hi", Hi, 32'h0);
    chk("rst_lo", Lo, 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_done", 32'(Done), 32'h0);
    chk("rst_dz", 32'(DivZero), 32'h0);
    reset = 1'b1;

    // Table-driven multiplies and divides, back to back.
    ph = 32'h0; pl = 32'h0;
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].is_mult, ~vecs[i].is_mult, vecs[i].a, vecs[i].b, 0, ph, pl,
             bn, dn, rh, rl, rdz, held);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bn), 32'd32);
      chk($sformatf("v%0d_done_cycles", i), 32'(dn), 32'd1);
      chk($sformatf("v%0d_hi", i), rh, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), rl, vecs[i].exp_lo);
      chk($sformatf("v%0d_divzero", i), 32'(rdz), 32'h0);
      chk($sformatf("v%0d_hold", i), 32'(held), 32'h1);
      ph = vecs[i].exp_hi; pl = vecs[i].exp_lo;
    end

    // Divide by zero with Hi=2, Lo=14 preloaded by the last vector.
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 0, ph, pl, bn, dn, rh, rl, rdz, held);
    chk("dz_busy_cycles", 32'(bn), 32'd0);
    chk("dz_done_cycles", 32'(dn), 32'd1);
    chk("dz_flag", 32'(rdz), 32'h1);
    chk("dz_hi", rh, 32'd2);
    chk("dz_lo", rl, 32'd14);
    chk("dz_sticky", 32'(DivZero), 32'h1);

    // Next multiply clears DivZero at its start edge.
    @(negedge clock);
    A = 32'd3; B = 32'd4; MultStart = 1'b1;
    @(negedge clock);
    MultStart = 1'b0;
    chk("dz_cleared", 32'(DivZero), 32'h0);
    chk("mul_after_dz_busy", 32'(Busy), 32'h1);
    repeat (32) @(negedge clock);
    chk("mul_after_dz_done", 32'(Done), 32'h1);
    chk("mul_after_dz_lo", Lo, 32'd12);
    chk("mul_after_dz_hi", Hi, 32'd0);
    ph = 32'd0; pl = 32'd12;

    // Both starts together: multiply wins.
    run_op(1'b1, 1'b1, 32'd6, 32'd7, 0, ph, pl, bn, dn, rh, rl, rdz, held);
    chk("both_hi", rh, 32'd0);
    chk("both_lo", rl, 32'd42);
    chk("both_busy_cycles", 32'(bn), 32'd32);
    ph = 32'd0; pl = 32'd42;

    // DivStart pulsed during iteration 10 of a multiply is ignored.
    run_op(1'b1, 1'b0, 32'h0000_1234, 32'h0000_0010, 10, ph, pl, bn, dn, rh, rl, rdz, held);
    chk("inj_hi", rh, 32'd0);
    chk("inj_lo", rl, 32'h0001_2340);
    chk("inj_busy_cycles", 32'(bn), 32'd32);
    chk("inj_done_cycles", 32'(dn), 32'd1);
    chk("inj_idle_after", 32'(Busy), 32'h0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clock);
    A = 32'd7; B = 32'd3; MultStart = 1'b1;
    @(negedge clock);
    MultStart = 1'b0;
    repeat (9) @(negedge clock);
    chk("pre_rst_busy", 32'(Busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_hi", Hi, 32'h0);
    chk("midrst_lo", Lo, 32'h0);
    chk("midrst_busy", 32'(Busy), 32'h0);
    chk("midrst_done", 32'(Done), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (Busy || Done || Hi != 32'h0 || Lo != 32'h0) quiet = 1'b0;
    end
    chk("post_rst_idle", 32'(quiet), 32'h1);

    // Unit still works after the abort.
    run_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3, 0, 32'h0, 32'h0, bn, dn, rh, rl, rdz, held);
    chk("post_rst_hi", rh, 32'hFFFF_FFFF);
    chk("post_rst_lo", rl, 32'hFFFF_FFFA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit for MULT and DIV.
- Sits directly downstream of the A/B operand registers of the multicycle datapath and produces the Hi/Lo result registers that later MFHI/MFLO write-back consumes.
- The control unit pulses a start, holds its state machine while Busy is high, and advances on Done.
- Divide-by-zero is flagged so the control unit can raise an exception through the Cause/EPC path.

Parameters:
- WIDTH, 32, operand width; also the iteration count of each operation.

Ports:
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- A  in  WIDTH  operand 1 (multiplicand / dividend), from A register
- B  in  WIDTH  operand 2 (multiplier / divisor), from B register
- MultStart  in  1  request signed multiply, sampled at rising edge
- DivStart  in  1  request signed divide, sampled at rising edge
- Hi  out  WIDTH  upper product word / remainder
- Lo  out  WIDTH  lower product word / quotient
- Busy  out  1  operation in progress
- Done  out  1  one-cycle completion pulse
- DivZero  out  1  last accepted divide had B == 0

Behaviour:
- Reset (reset == 0, asynchronous):
  - state = IDLE.
  - Hi, Lo, Busy, Done, DivZero and all internal working registers = 0.
  - Applies at any time, including mid-operation: the operation is aborted and no result is written.
- States: IDLE, MULT, DIV, DONE. Busy = 1 exactly in MULT and DIV. Done = 1 exactly in DONE.
- IDLE:
  - Start accepted at an edge where MultStart or DivStart is 1.
  - If both are 1, MultStart wins; DivStart is dropped.
  - On acceptance: A and B captured into working registers, iteration counter loaded with WIDTH, DivZero cleared.
  - Next state MULT or DIV.
- Starts seen in MULT, DIV or DONE are ignored; they are not queued.
- MULT:
  - Radix-2 Booth, one step per edge, using a 2*WIDTH+1-bit accumulator.
  - After WIDTH steps, the edge that completes the last step writes Hi = product[2W-1:W] and Lo = product[W-1:0], then enters DONE.
  - Result is the full signed 2W-bit product; no overflow.
- DIV:
  - Signed restoring division on magnitudes, one quotient bit per edge, WIDTH steps.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - The final edge writes Lo = quotient and Hi = remainder (sign-corrected), then enters DONE.
  - B == 0 at acceptance: no iterations. The next edge enters DONE with DivZero = 1; Hi and Lo are unchanged.
  - A = 0x80000000, B = 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0 (wraps; no flag).
- Latency:
  - Start edge E0; iteration edges E1..EW; Done high during the cycle after EW; IDLE after E(W+1).
  - Divide-by-zero: Done high the cycle after E0.
  - A new start is accepted no earlier than E(W+2), i.e. the first edge in IDLE.
- Hi and Lo hold their previous values throughout MULT/DIV and change only at the completing edge.
- DivZero is sticky until the next accepted start.
- A and B need not be held stable after E0.

Test Plan:
- Multiply 7 × −3: A=7, B=0xFFFFFFFD, MultStart pulse → Busy for 32 cycles, Done for 1 cycle, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, DivZero=0.
- Multiply extremes: A=B=0x80000000 → Hi=0x40000000, Lo=0x00000000. Then A=0xFFFFFFFF, B=0x00000002 → Hi=0xFFFFFFFF, Lo=0xFFFFFFFE.
- Divide signs:
  - A=−7 (0xFFFFFFF9), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - A=7, B=−2 → Lo=0xFFFFFFFD, Hi=0x00000001.
  - A=100, B=7 → Lo=14, Hi=2.
- Divide by zero: preload Hi=2, Lo=14; A=5, B=0, DivStart → Done the cycle after the start edge, DivZero=1, Hi/Lo unchanged. A following MultStart clears DivZero.
- Overflow divide: A=0x80000000, B=0xFFFFFFFF → Lo=0x80000000, Hi=0, DivZero=0.
- Control edges:
  - MultStart and DivStart high together → multiply performed.
  - DivStart pulsed at iteration 10 of a multiply → ignored; multiply result correct.
  - reset driven low at iteration 10 → Hi=Lo=Busy=Done=0 immediately; after release, stays IDLE until a new start.
